// File: rtl/mod_counter_prog.sv
`default_nettype none
// ============================================================================
// Module  : mod_counter_prog
// Brief   : Runtime-programmable modulus counter with up/down, load,
//           wrap/saturate modes and a combinational cascade carry (tc).
//           Optional wrap-event counter enabled by MOD_COUNTER_WRAPCNT_EN.
// Revision: 1.0  initial release
// ============================================================================
module mod_counter_prog #(
  parameter int WIDTH  = 8,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up,
  input  logic              sat,
  input  logic [WIDTH-1:0]  mod_val,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap,
  output logic              at_limit,
  output logic [WCNT_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_at_limit;

  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_term;
  logic             w_wrap_evt;

  // mod_val == 0 underflows to all ones, which is exactly TOP for M = 2^WIDTH.
  assign w_top          = mod_val - C_ONE;
  assign w_term         = up ? (r_count >= w_top) : (r_count == '0);
  assign w_load_clamped = (load_val > w_top) ? w_top : load_val;
  assign tc             = enable & ~load & w_term & ~sat;
  assign w_wrap_evt     = tc & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_at_limit <= 1'b0;
    end else if (load) begin
      r_count    <= w_load_clamped;
      r_wrap     <= 1'b0;
      r_at_limit <= 1'b0;
    end else if (enable) begin
      if (!w_term) begin
        r_count    <= up ? (r_count + C_ONE) : (r_count - C_ONE);
        r_wrap     <= 1'b0;
        r_at_limit <= 1'b0;
      end else if (!sat) begin
        r_count    <= up ? '0 : w_top;
        r_wrap     <= 1'b1;
        r_at_limit <= 1'b0;
      end else begin
        r_wrap     <= 1'b0;
        r_at_limit <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign at_limit = r_at_limit;

`ifdef MOD_COUNTER_WRAPCNT_EN
  logic [WCNT_W-1:0] r_wrap_cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap_evt && (r_wrap_cnt != {WCNT_W{1'b1}})) begin
      r_wrap_cnt <= r_wrap_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`else
  logic w_unused;
  assign w_unused = w_wrap_evt;
  assign wrap_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_prog.sv
`default_nettype none
// Scoreboard bench for mod_counter_prog (WIDTH=4): directed scenarios,
// randomized traffic against an arithmetic reference model, and a cascade pair.
module tb_mod_counter_prog;

  localparam int W  = 4;
  localparam int WC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, enable = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
  logic [W-1:0]  mod_val = '0, load_val = '0;
  logic [W-1:0]  count;
  logic          tc, wrap, at_limit;
  logic [WC-1:0] wrap_cnt;

  mod_counter_prog #(.WIDTH(W), .WCNT_W(WC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .sat(sat),
    .mod_val(mod_val), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap), .at_limit(at_limit), .wrap_cnt(wrap_cnt)
  );

  // Cascade pair: low stage carry feeds the high stage enable.
  logic          c_rst = 1'b1, c_en = 1'b0, c_up = 1'b1, c_sat = 1'b0, c_load = 1'b0;
  logic [W-1:0]  c_mod = 4'd10, c_lv = '0;
  logic [W-1:0]  lo_count, hi_count;
  logic          lo_tc, hi_tc, lo_wrap, hi_wrap, lo_al, hi_al;
  logic [WC-1:0] lo_wc, hi_wc;

  mod_counter_prog #(.WIDTH(W), .WCNT_W(WC)) u_lo (
    .clk(clk), .rst(c_rst), .enable(c_en), .up(c_up), .sat(c_sat),
    .mod_val(c_mod), .load(c_load), .load_val(c_lv),
    .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .at_limit(lo_al), .wrap_cnt(lo_wc)
  );

  mod_counter_prog #(.WIDTH(W), .WCNT_W(WC)) u_hi (
    .clk(clk), .rst(c_rst), .enable(lo_tc), .up(c_up), .sat(c_sat),
    .mod_val(c_mod), .load(c_load), .load_val(c_lv),
    .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .at_limit(hi_al), .wrap_cnt(hi_wc)
  );

  typedef struct {
    int cnt;
    int wr;
    int al;
    int wc;
    int tcv;
  } exp_t;

  exp_t sbq[$];
  int   m_cnt = 0, m_wr = 0, m_al = 0, m_wc = 0;
  int   passed = 0, total = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Drive one cycle of inputs, record what the DUT must show during this
  // cycle, then advance the model to the state after the coming edge.
  task automatic step(input bit r, input bit e, input bit u, input bit s,
                      input int mv, input bit ld, input int lv);
    int   m;
    int   top;
    bit   term;
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; enable = e; up = u; sat = s; load = ld;
    mod_val = mv[W-1:0]; load_val = lv[W-1:0];
    m    = (mv == 0) ? (1 << W) : mv;
    top  = m - 1;
    term = u ? (m_cnt >= top) : (m_cnt == 0);
    x.cnt = m_cnt; x.wr = m_wr; x.al = m_al; x.wc = m_wc;
    x.tcv = (e && !ld && term && !s) ? 1 : 0;
    sbq.push_back(x);
    if (r) begin
      m_cnt = 0; m_wr = 0; m_al = 0; m_wc = 0;
    end else if (ld) begin
      m_cnt = (lv > top) ? top : lv;
      m_wr = 0; m_al = 0; m_wc = 0;
    end else if (e) begin
      if (!term) begin
        m_cnt = u ? m_cnt + 1 : m_cnt - 1;
        m_wr = 0; m_al = 0;
      end else if (!s) begin
        m_cnt = u ? 0 : top;
        m_wr = 1; m_al = 0;
`ifdef MOD_COUNTER_WRAPCNT_EN
        if (m_wc < (1 << WC) - 1) m_wc = m_wc + 1;
`endif
      end else begin
        m_wr = 0; m_al = 1;
      end
    end else begin
      m_wr = 0;
    end
  endtask

  task automatic chk_now(input string name, input int exp_cnt, input int exp_wr,
                         input int exp_al);
    @(negedge clk);
    chk({name, "_count"}, int'(count), exp_cnt);
    chk({name, "_wrap"}, int'(wrap), exp_wr);
    chk({name, "_at_limit"}, int'(at_limit), exp_al);
  endtask

  // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("sb_count", int'(count), x.cnt);
      chk("sb_wrap", int'(wrap), x.wr);
      chk("sb_at_limit", int'(at_limit), x.al);
      chk("sb_wrap_cnt", int'(wrap_cnt), x.wc);
      chk("sb_tc", int'(tc), x.tcv);
    end
  end

  initial begin
    bit cur_up, cur_sat;
    int cur_mod;

    // Reset then wrap up with M=10
    step(1, 0, 1, 0, 10, 0, 0);
    repeat (12) step(0, 1, 1, 0, 10, 0, 0);
    step(0, 0, 1, 0, 10, 0, 0);
    chk_now("wrap_up", 2, 0, 0);

    // Full-range down count from 0
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_now("down_first", 15, 1, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_now("down_more", 13, 0, 0);

    // Saturate at TOP=5, then step down out of it
    step(1, 0, 1, 1, 6, 0, 0);
    repeat (8) step(0, 1, 1, 1, 6, 0, 0);
    step(0, 0, 1, 1, 6, 0, 0);
    chk_now("sat_hold", 5, 0, 1);
    step(0, 1, 0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 6, 0, 0);
    chk_now("sat_release", 4, 0, 0);

    // Load beats enable and is clamped; reset beats load
    step(0, 1, 1, 0, 8, 1, 12);
    step(0, 0, 1, 0, 8, 0, 0);
    chk_now("load_clamp", 7, 0, 0);
    step(1, 1, 1, 0, 8, 1, 12);
    step(0, 0, 1, 0, 8, 0, 0);
    chk_now("rst_over_load", 0, 0, 0);

    // Modulus shrink below current count
    step(0, 0, 1, 0, 12, 1, 9);
    step(0, 1, 1, 0, 5, 0, 0);
    step(0, 0, 1, 0, 5, 0, 0);
    chk_now("mod_shrink", 0, 1, 0);

    // M=1: every enabled edge wraps, wrap stays high
    repeat (4) step(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    chk_now("m_one", 0, 1, 0);

    // Randomized traffic
    cur_up = 1'b1; cur_sat = 1'b0; cur_mod = 10;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_up = ~cur_up;
      if ($urandom_range(0, 24) == 0) cur_sat = ~cur_sat;
      if ($urandom_range(0, 29) == 0) cur_mod = $urandom_range(0, 15);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), cur_up, cur_sat,
           cur_mod, ($urandom_range(0, 9) == 0), $urandom_range(0, 15));
    end
    step(0, 0, 1, 0, 10, 0, 0);
    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);

    // Cascade: 25 enables into two M=10 stages
    @(posedge clk);
    #2;
    c_rst = 1'b0;
    c_en  = 1'b1;
    repeat (25) @(posedge clk);
    #2;
    c_en = 1'b0;
    @(negedge clk);
    chk("cascade_hi", int'(hi_count), 2);
    chk("cascade_lo", int'(lo_count), 5);
`ifdef MOD_COUNTER_WRAPCNT_EN
    chk("cascade_lo_wrap_cnt", int'(lo_wc), 2);
`else
    chk("cascade_lo_wrap_cnt", int'(lo_wc), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
